// File: rtl/fetch_sequencer.sv
// Program-counter sequencer: drives imem address, captures the registered read data, hands it to decode/FPU via valid/ready.
// Optional FETCH_PERF_CNT_EN adds a saturating completed-handshake counter on fetch_cnt_o.
module fetch_sequencer #(
    parameter int              PC_W     = 8,
    parameter int              INST_W   = 16,
    parameter logic [PC_W-1:0] PC_RESET = '0,
    parameter logic [3:0]      HALT_OP  = 4'hF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run_i,
    input  logic              stop_i,
    output logic [PC_W-1:0]   pc_o,
    input  logic [INST_W-1:0] imem_inst_i,
    output logic [INST_W-1:0] inst_o,
    output logic              inst_valid_o,
    input  logic              inst_ready_i,
    input  logic              branch_en_i,
    input  logic [PC_W-1:0]   branch_target_i,
`ifdef FETCH_PERF_CNT_EN
    output logic [15:0]       fetch_cnt_o,
`endif
    output logic              halted_o,
    output logic              busy_o
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_VALID, S_HALT} state_t;

    state_t            state_q;
    logic [PC_W-1:0]   pc_q;
    logic [INST_W-1:0] inst_q;
    logic              valid_q;
    logic              halted_q;
    logic              busy_q;

    logic launch;
    logic handshake;

    // A launch or handshake only counts when stop_i does not override it.
    assign launch    = run_i & ~stop_i & ((state_q == S_IDLE) | (state_q == S_HALT));
    assign handshake = valid_q & inst_ready_i & ~stop_i;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            pc_q     <= PC_RESET;
            inst_q   <= '0;
            valid_q  <= 1'b0;
            halted_q <= 1'b0;
            busy_q   <= 1'b0;
        end else if (stop_i) begin
            state_q  <= S_HALT;
            inst_q   <= '0;
            valid_q  <= 1'b0;
            halted_q <= 1'b1;
            busy_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_HALT: begin
                    if (run_i) begin
                        state_q  <= S_ISSUE;
                        pc_q     <= PC_RESET;
                        halted_q <= 1'b0;
                        busy_q   <= 1'b1;
                    end
                end
                S_ISSUE: begin
                    // A HALT word is swallowed here and never presented downstream.
                    if (imem_inst_i[INST_W-1 -: 4] == HALT_OP) begin
                        state_q  <= S_HALT;
                        inst_q   <= '0;
                        halted_q <= 1'b1;
                        busy_q   <= 1'b0;
                    end else begin
                        state_q <= S_VALID;
                        inst_q  <= imem_inst_i;
                        valid_q <= 1'b1;
                    end
                end
                S_VALID: begin
                    if (inst_ready_i) begin
                        state_q <= S_ISSUE;
                        valid_q <= 1'b0;
                        pc_q    <= branch_en_i ? branch_target_i : pc_q + PC_W'(1);
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [15:0] cnt_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (launch) begin
            cnt_q <= '0;
        end else if (handshake && cnt_q != 16'hFFFF) begin
            cnt_q <= cnt_q + 16'd1;
        end
    end

    assign fetch_cnt_o = cnt_q;
`else
    logic unused_ok;
    assign unused_ok = launch ^ handshake;
`endif

    assign pc_o         = pc_q;
    assign inst_o       = inst_q;
    assign inst_valid_o = valid_q;
    assign halted_o     = halted_q;
    assign busy_o       = busy_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer; memory is modelled as data for pc_o available at the edge ending that cycle.
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        run_i;
    logic        stop_i;
    logic [7:0]  pc_o;
    logic [15:0] imem_inst_i;
    logic [15:0] inst_o;
    logic        inst_valid_o;
    logic        inst_ready_i;
    logic        branch_en_i;
    logic [7:0]  branch_target_i;
    logic        halted_o;
    logic        busy_o;
`ifdef FETCH_PERF_CNT_EN
    logic [15:0] fetch_cnt_o;
`endif

    logic [15:0] mem [256];
    int passed = 0;
    int total  = 0;

    assign imem_inst_i = mem[pc_o];

    always #5 clk = ~clk;

    fetch_sequencer dut (
        .clk             (clk),
        .rst             (rst),
        .run_i           (run_i),
        .stop_i          (stop_i),
        .pc_o            (pc_o),
        .imem_inst_i     (imem_inst_i),
        .inst_o          (inst_o),
        .inst_valid_o    (inst_valid_o),
        .inst_ready_i    (inst_ready_i),
        .branch_en_i     (branch_en_i),
        .branch_target_i (branch_target_i),
`ifdef FETCH_PERF_CNT_EN
        .fetch_cnt_o     (fetch_cnt_o),
`endif
        .halted_o        (halted_o),
        .busy_o          (busy_o)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; run_i = 1'b0; stop_i = 1'b0; inst_ready_i = 1'b0;
        branch_en_i = 1'b0; branch_target_i = 8'h00;
        step(); step();
        total++;
        if ({pc_o, inst_o, inst_valid_o, halted_o, busy_o} !== 27'd0)
            $display("FAIL reset_outputs: pc=%h inst=%h v=%b h=%b b=%b, want all zero",
                     pc_o, inst_o, inst_valid_o, halted_o, busy_o);
        else passed++;
`ifdef FETCH_PERF_CNT_EN
        total++;
        if (fetch_cnt_o !== 16'd0) $display("FAIL reset_cnt: got %0d want 0", fetch_cnt_o);
        else passed++;
`endif
        rst = 1'b1;
        step();
        total++;
        if (busy_o !== 1'b0 || halted_o !== 1'b0 || pc_o !== 8'h00)
            $display("FAIL idle_hold: busy=%b halted=%b pc=%h, want 0 0 00", busy_o, halted_o, pc_o);
        else passed++;
    endtask

    task automatic test_run();
        logic [7:0]  exp_pc   [4] = '{8'h00, 8'h00, 8'h01, 8'h01};
        logic        exp_v    [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        logic [15:0] exp_inst [4] = '{16'h0000, 16'h1234, 16'h1234, 16'h5678};
        inst_ready_i = 1'b1;
        run_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            run_i = 1'b0;
            if (i == 3) inst_ready_i = 1'b0;
            total++;
            if (pc_o !== exp_pc[i] || inst_valid_o !== exp_v[i] || busy_o !== 1'b1 ||
                (exp_v[i] && inst_o !== exp_inst[i]))
                $display("FAIL run_seq[%0d]: pc=%h v=%b inst=%h busy=%b, want pc=%h v=%b inst=%h busy=1",
                         i, pc_o, inst_valid_o, inst_o, busy_o, exp_pc[i], exp_v[i], exp_inst[i]);
            else passed++;
        end
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < 5; i++) begin
            step();
            total++;
            if (inst_o !== 16'h5678 || pc_o !== 8'h01 || inst_valid_o !== 1'b1)
                $display("FAIL bp_hold[%0d]: inst=%h pc=%h v=%b, want 5678 01 1", i, inst_o, pc_o, inst_valid_o);
            else passed++;
        end
        inst_ready_i = 1'b1;
        step();
        inst_ready_i = 1'b0;
        total++;
        if (pc_o !== 8'h02 || inst_valid_o !== 1'b0)
            $display("FAIL bp_release: pc=%h v=%b, want 02 0", pc_o, inst_valid_o);
        else passed++;
        step();
        total++;
        if (pc_o !== 8'h02 || inst_valid_o !== 1'b1 || inst_o !== 16'h0102)
            $display("FAIL bp_next: pc=%h v=%b inst=%h, want 02 1 0102", pc_o, inst_valid_o, inst_o);
        else passed++;
    endtask

    task automatic test_branch();
        inst_ready_i = 1'b1;
        step();
        inst_ready_i = 1'b0;
        step();
        branch_en_i = 1'b1; branch_target_i = 8'h40;
        step();
        total++;
        if (pc_o !== 8'h03 || inst_valid_o !== 1'b1 || inst_o !== 16'h0103)
            $display("FAIL branch_no_ready: pc=%h v=%b inst=%h, want 03 1 0103", pc_o, inst_valid_o, inst_o);
        else passed++;
        inst_ready_i = 1'b1;
        step();
        branch_en_i = 1'b0; inst_ready_i = 1'b0;
        total++;
        if (pc_o !== 8'h40 || inst_valid_o !== 1'b0)
            $display("FAIL branch_pc: pc=%h v=%b, want 40 0", pc_o, inst_valid_o);
        else passed++;
        step();
        total++;
        if (pc_o !== 8'h40 || inst_valid_o !== 1'b1 || inst_o !== 16'h0140)
            $display("FAIL branch_inst: pc=%h v=%b inst=%h, want 40 1 0140", pc_o, inst_valid_o, inst_o);
        else passed++;
    endtask

    task automatic test_wrap_stop();
        branch_en_i = 1'b1; branch_target_i = 8'hFF; inst_ready_i = 1'b1;
        step();
        branch_en_i = 1'b0; inst_ready_i = 1'b0;
        step();
        total++;
        if (pc_o !== 8'hFF || inst_o !== 16'h01FF || inst_valid_o !== 1'b1)
            $display("FAIL wrap_ff: pc=%h inst=%h v=%b, want FF 01FF 1", pc_o, inst_o, inst_valid_o);
        else passed++;
        inst_ready_i = 1'b1;
        step();
        inst_ready_i = 1'b0;
        total++;
        if (pc_o !== 8'h00) $display("FAIL wrap_00: pc=%h want 00", pc_o);
        else passed++;
        step();
        stop_i = 1'b1; inst_ready_i = 1'b1;
        step();
        stop_i = 1'b0; inst_ready_i = 1'b0;
        total++;
        if (halted_o !== 1'b1 || inst_o !== 16'h0 || inst_valid_o !== 1'b0 || pc_o !== 8'h00 || busy_o !== 1'b0)
            $display("FAIL stop_halt: h=%b inst=%h v=%b pc=%h busy=%b, want 1 0000 0 00 0",
                     halted_o, inst_o, inst_valid_o, pc_o, busy_o);
        else passed++;
        branch_en_i = 1'b1; branch_target_i = 8'h30;
        run_i = 1'b1;
        step();
        run_i = 1'b0; branch_en_i = 1'b0;
        step();
        step();
        total++;
        if (inst_valid_o !== 1'b1 || pc_o !== 8'h00)
            $display("FAIL restart_valid: v=%b pc=%h, want 1 00", inst_valid_o, pc_o);
        else passed++;
        rst = 1'b0;
        step();
        total++;
        if ({pc_o, inst_o, inst_valid_o, halted_o, busy_o} !== 27'd0)
            $display("FAIL rst_mid_valid: pc=%h inst=%h v=%b h=%b b=%b, want all zero",
                     pc_o, inst_o, inst_valid_o, halted_o, busy_o);
        else passed++;
        rst = 1'b1;
        step();
    endtask

    task automatic test_halt();
        int delivered = 0;
        mem[2] = 16'hF000;
        inst_ready_i = 1'b1;
        run_i = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            run_i = 1'b0;
            if (inst_valid_o) begin
                delivered++;
                total++;
                if (inst_o[15:12] === 4'hF)
                    $display("FAIL halt_word_delivered: inst=%h at pc=%h", inst_o, pc_o);
                else passed++;
            end
        end
        total++;
        if (delivered != 2) $display("FAIL halt_delivered_count: got %0d want 2", delivered);
        else passed++;
        total++;
        if (halted_o !== 1'b1 || pc_o !== 8'h02 || inst_valid_o !== 1'b0 || inst_o !== 16'h0)
            $display("FAIL halt_state: h=%b pc=%h v=%b inst=%h, want 1 02 0 0000",
                     halted_o, pc_o, inst_valid_o, inst_o);
        else passed++;
        run_i = 1'b1;
        step();
        run_i = 1'b0;
        total++;
        if (halted_o !== 1'b0 || pc_o !== 8'h00 || busy_o !== 1'b1)
            $display("FAIL halt_restart: h=%b pc=%h busy=%b, want 0 00 1", halted_o, pc_o, busy_o);
        else passed++;
        inst_ready_i = 1'b0;
        mem[2] = 16'h0102;
    endtask

`ifdef FETCH_PERF_CNT_EN
    task automatic test_perf_cnt();
        rst = 1'b0;
        step();
        rst = 1'b1;
        mem[3] = 16'hF123;
        inst_ready_i = 1'b1;
        run_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            run_i = 1'b0;
        end
        total++;
        if (halted_o !== 1'b1 || fetch_cnt_o !== 16'd3)
            $display("FAIL perf_cnt3: halted=%b cnt=%0d, want 1 3", halted_o, fetch_cnt_o);
        else passed++;
        step(); step();
        total++;
        if (fetch_cnt_o !== 16'd3) $display("FAIL perf_hold: cnt=%0d want 3", fetch_cnt_o);
        else passed++;
        inst_ready_i = 1'b0;
        run_i = 1'b1;
        step();
        run_i = 1'b0;
        total++;
        if (fetch_cnt_o !== 16'd0) $display("FAIL perf_clear: cnt=%0d want 0", fetch_cnt_o);
        else passed++;
        mem[3] = 16'h0103;
    endtask
`endif

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'h0100 + 16'(i);
        mem[0] = 16'h1234;
        mem[1] = 16'h5678;
        test_reset();
        test_run();
        test_backpressure();
        test_branch();
        test_wrap_stop();
        test_halt();
`ifdef FETCH_PERF_CNT_EN
        test_perf_cnt();
`endif
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Program-counter controller for the 8-bit-addressed, 16-bit-wide instruction memory feeding the floating-point arithmetic unit.
- Drives the memory address and accounts for the memory's one-cycle registered read latency.
- Presents each fetched instruction to decode/FPU through a valid/ready handshake.
- Supports taken branches, a HALT opcode and an external stop.

Parameters:
- PC_W, 8, width of program counter and memory address.
- INST_W, 16, instruction width.
- PC_RESET, 0, start address used on reset and on every run_i launch.
- HALT_OP, 4'hF, value of inst[INST_W-1:INST_W-4] that terminates fetch.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  reset, synchronous, active-low.
- run_i  input  1  start pulse; honoured only in IDLE or HALT.
- stop_i  input  1  synchronous abort; forces HALT.
- pc_o  output  PC_W  address to instruction memory.
- imem_inst_i  input  INST_W  registered memory read data, valid one cycle after pc_o.
- inst_o  output  INST_W  instruction to consumer.
- inst_valid_o  output  1  inst_o holds a valid instruction.
- inst_ready_i  input  1  consumer accepts inst_o.
- branch_en_i  input  1  taken branch, sampled only on a handshake cycle.
- branch_target_i  input  PC_W  branch destination.
- halted_o  output  1  high in HALT state.
- busy_o  output  1  high in ISSUE or VALID.

Behaviour:
- All state updates on posedge clk.
- Priority: rst low > stop_i > handshake/branch > run_i.
- Reset (rst==0):
  - state=IDLE, pc_o=PC_RESET, inst_o=0, inst_valid_o=0, halted_o=0, busy_o=0.
  - Reset mid-fetch discards any in-flight instruction; nothing is delivered.
- IDLE: all outputs at reset values. run_i=1 -> pc_o=PC_RESET, go ISSUE.
- ISSUE (one cycle): pc_o stable. Memory returns data at the following edge, which captures imem_inst_i into inst_o.
  - If the captured opcode field equals HALT_OP: go HALT. inst_valid_o stays 0; the HALT word is never delivered.
  - Otherwise: inst_valid_o=1, go VALID.
- VALID: inst_o, inst_valid_o and pc_o are held stable while inst_ready_i=0, for any number of cycles.
- Handshake in VALID (inst_valid_o & inst_ready_i):
  - inst_valid_o clears next cycle.
  - pc_o = branch_en_i ? branch_target_i : pc_o+1, modulo 2^PC_W (0xFF+1 -> 0x00).
  - Go ISSUE.
- branch_en_i outside a handshake cycle is ignored.
- Throughput is one instruction per 2 cycles minimum: handshake, ISSUE bubble, valid again.
- HALT: halted_o=1, inst_valid_o=0, inst_o=0, pc_o holds the address of the HALT word (or the current address on stop).
  - run_i=1 with stop_i=0 -> halted_o=0, pc_o=PC_RESET, go ISSUE.
- stop_i=1 in any non-reset state: next cycle state=HALT, inst_valid_o=0, inst_o=0, pc_o frozen.
  - A handshake in the same cycle as stop_i is dropped: the consumer must treat it as not accepted, and pc_o does not advance.
  - stop_i in IDLE also enters HALT.
- run_i while in ISSUE or VALID is ignored.
- busy_o = (state==ISSUE)|(state==VALID), registered with state.

Optional Feature:
- Macro FETCH_PERF_CNT_EN.
- Defined:
  - Adds output fetch_cnt_o [15:0], reset to 0.
  - Increments by 1 on each completed handshake; saturates at 16'hFFFF.
  - Cleared on every run_i launch.
  - Holds its value through HALT.
- Undefined: the port and the counter do not exist; all other behaviour is identical.

Test Plan:
- Reset then run_i: memory holds 0x1234 at 0, 0x5678 at 1, ready tied high.
  - pc_o sequence 0,0,1,1.
  - inst_o 0x1234 valid 2 cycles after run_i, then 0x5678 two cycles later.
- Back-pressure: ready low for 5 cycles while valid.
  - inst_o, pc_o and valid stay constant for all 5 cycles.
  - One handshake when ready rises; pc advances by 1 exactly once.
- Branch: handshake at pc 0x03 with branch_en_i=1, target 0x40 -> next pc_o=0x40 and inst_o=mem[0x40]. branch_en_i=1 without ready -> ignored.
- HALT: mem[2]=0xF000.
  - Instructions at 0 and 1 are delivered; the 0xF000 word is never valid.
  - halted_o=1, pc_o=2.
  - run_i restarts at pc 0.
- Wrap and stop:
  - Branch to 0xFF then handshake -> pc_o=0x00.
  - stop_i asserted together with ready -> next cycle halted_o=1, inst_o=0, pc_o unchanged.
  - rst low during VALID -> all outputs at reset values next cycle.
- FETCH_PERF_CNT_EN defined: 3 handshakes -> fetch_cnt_o=3; stays 3 in HALT; 0 after run_i.
